// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte transceiver (MSB first), oversampled in the clk_sys_i domain.
// Optional macro SPI_BYTE_SYNC_EN inserts 2-flop synchronizers on the SPI inputs.
module spi_byte_shifter (
  input  logic       clk_sys_i,
  input  logic       reset_i,
  input  logic       spi_sck_i,
  input  logic       spi_cs_ni,
  input  logic       spi_rx_i,
  output logic       spi_tx_o,
  input  logic [7:0] tx_byte_i,
  output logic [7:0] rx_byte_o,
  output logic       valid_o
);

  logic sck_s;
  logic cs_s;
  logic rx_s;

`ifdef SPI_BYTE_SYNC_EN
  logic [1:0] sck_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] rx_sync_q;

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      sck_sync_q <= 2'b00;
      cs_sync_q  <= 2'b11;
      rx_sync_q  <= 2'b00;
    end else begin
      sck_sync_q <= {sck_sync_q[0], spi_sck_i};
      cs_sync_q  <= {cs_sync_q[0], spi_cs_ni};
      rx_sync_q  <= {rx_sync_q[0], spi_rx_i};
    end
  end

  assign sck_s = sck_sync_q[1];
  assign cs_s  = cs_sync_q[1];
  assign rx_s  = rx_sync_q[1];
`else
  assign sck_s = spi_sck_i;
  assign cs_s  = spi_cs_ni;
  assign rx_s  = spi_rx_i;
`endif

  logic       sck_q;
  logic       cs_q;
  logic [7:0] tx_sr_q,   tx_sr_d;
  logic [7:0] rx_sr_q,   rx_sr_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       valid_q,   valid_d;

  logic sck_rise;
  logic sck_fall;
  logic active;

  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  // Edges count only once CS has been low for a full clk, so a glitchy CS
  // assertion cannot clock a bit in the same cycle it lands.
  assign active   = ~cs_s & ~cs_q;

  always_comb begin
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_byte_d = rx_byte_q;
    bit_cnt_d = bit_cnt_q;
    valid_d   = 1'b0;

    if (cs_s) begin
      tx_sr_d   = tx_byte_i;
      bit_cnt_d = 3'd0;
    end else if (active) begin
      if (sck_rise) begin
        rx_sr_d   = {rx_sr_q[6:0], rx_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte_d = {rx_sr_q[6:0], rx_s};
          valid_d   = 1'b1;
        end
      end else if (sck_fall) begin
        // bit_cnt already wrapped to 0 on the 8th rise: load the next byte
        if (bit_cnt_q == 3'd0) begin
          tx_sr_d = tx_byte_i;
        end else begin
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      tx_sr_q   <= 8'h00;
      rx_sr_q   <= 8'h00;
      rx_byte_q <= 8'h00;
      bit_cnt_q <= 3'd0;
      valid_q   <= 1'b0;
    end else begin
      sck_q     <= sck_s;
      cs_q      <= cs_s;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_byte_q <= rx_byte_d;
      bit_cnt_q <= bit_cnt_d;
      valid_q   <= valid_d;
    end
  end

  assign spi_tx_o  = tx_sr_q[7];
  assign rx_byte_o = rx_byte_q;
  assign valid_o   = valid_q;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Directed bench for spi_byte_shifter: vector table plus multi-cycle corner sequences.
module tb_spi_byte_shifter;

  logic       clk_sys_i = 1'b0;
  logic       reset_i;
  logic       spi_sck_i;
  logic       spi_cs_ni;
  logic       spi_rx_i;
  logic       spi_tx_o;
  logic [7:0] tx_byte_i;
  logic [7:0] rx_byte_o;
  logic       valid_o;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount   = 0;

  always #5 clk_sys_i = ~clk_sys_i;

  spi_byte_shifter dut (
    .clk_sys_i (clk_sys_i),
    .reset_i   (reset_i),
    .spi_sck_i (spi_sck_i),
    .spi_cs_ni (spi_cs_ni),
    .spi_rx_i  (spi_rx_i),
    .spi_tx_o  (spi_tx_o),
    .tx_byte_i (tx_byte_i),
    .rx_byte_o (rx_byte_o),
    .valid_o   (valid_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_sys_i) begin
    if (valid_o === 1'b1) begin
      vcount++;
      check("valid_while_cs_low", {31'd0, spi_cs_ni}, 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys_i);
    #1;
  endtask

  // One SCK period = 4 clk; pin value is captured just before each rising SCK.
  task automatic send_bits(input logic [7:0] rx_val, input int nbits, input bit loopback,
                           input bit mutate, input logic [7:0] next_tx,
                           output logic [7:0] tx_seen);
    tx_seen = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      automatic int i = 7 - k;
      tx_seen[i] = spi_tx_o;
      spi_rx_i   = loopback ? spi_tx_o : rx_val[i];
      spi_sck_i  = 1'b1;
      tick(1);
      if (mutate) tx_byte_i = (i == 0) ? next_tx : 8'($urandom_range(0, 255));
      tick(1);
      spi_sck_i = 1'b0;
      tick(2);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx_in;
    logic [7:0] exp_pin;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] seen;
    int v0;

    vecs[0] = '{tx: 8'hA5, rx_in: 8'h6E, exp_pin: 8'hA5, exp_rx: 8'h6E};
    vecs[1] = '{tx: 8'h00, rx_in: 8'hFF, exp_pin: 8'h00, exp_rx: 8'hFF};
    vecs[2] = '{tx: 8'hFF, rx_in: 8'h00, exp_pin: 8'hFF, exp_rx: 8'h00};
    vecs[3] = '{tx: 8'h81, rx_in: 8'h7E, exp_pin: 8'h81, exp_rx: 8'h7E};
    vecs[4] = '{tx: 8'h5A, rx_in: 8'hC3, exp_pin: 8'h5A, exp_rx: 8'hC3};

    // Reset with CS low so no preload can mask the cleared shift register
    reset_i   = 1'b1;
    spi_cs_ni = 1'b0;
    spi_sck_i = 1'b0;
    spi_rx_i  = 1'b0;
    tx_byte_i = 8'hFF;
    tick(2);
    reset_i = 1'b0;
    tick(3);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_rx_byte", {24'd0, rx_byte_o}, 32'h00);
    check("reset_tx_pin", {31'd0, spi_tx_o}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      tx_byte_i = vecs[v].tx;
      spi_cs_ni = 1'b1;
      tick(2);
      check("preload_msb", {31'd0, spi_tx_o}, {31'd0, vecs[v].exp_pin[7]});
      spi_cs_ni = 1'b0;
      tick(2);
      v0 = vcount;
      send_bits(vecs[v].rx_in, 8, 1'b0, 1'b0, 8'h00, seen);
      check("vec_tx_pin", {24'd0, seen}, {24'd0, vecs[v].exp_pin});
      check("vec_rx_byte", {24'd0, rx_byte_o}, {24'd0, vecs[v].exp_rx});
      check("vec_valid_pulses", vcount - v0, 32'd1);
      spi_cs_ni = 1'b1;
      tick(2);
      check("vec_valid_idle", {31'd0, valid_o}, 32'd0);
    end

    // Loopback, two bytes back-to-back with CS held low
    tx_byte_i = 8'h3C;
    spi_cs_ni = 1'b1;
    tick(2);
    spi_cs_ni = 1'b0;
    tick(2);
    tx_byte_i = 8'hC3;
    v0 = vcount;
    send_bits(8'h00, 8, 1'b1, 1'b0, 8'h00, seen);
    check("b2b_pin_0", {24'd0, seen}, 32'h3C);
    check("b2b_rx_0", {24'd0, rx_byte_o}, 32'h3C);
    send_bits(8'h00, 8, 1'b1, 1'b0, 8'h00, seen);
    check("b2b_pin_1", {24'd0, seen}, 32'hC3);
    check("b2b_rx_1", {24'd0, rx_byte_o}, 32'hC3);
    check("b2b_valid_pulses", vcount - v0, 32'd2);
    spi_cs_ni = 1'b1;
    tick(2);

    // tx_byte_i churns after every rise; only the reload value reaches the pin
    tx_byte_i = 8'h5A;
    tick(2);
    spi_cs_ni = 1'b0;
    tick(2);
    send_bits(8'h11, 8, 1'b0, 1'b1, 8'hE7, seen);
    check("churn_pin_0", {24'd0, seen}, 32'h5A);
    send_bits(8'h22, 8, 1'b0, 1'b1, 8'h00, seen);
    check("churn_pin_1", {24'd0, seen}, 32'hE7);
    check("churn_rx_1", {24'd0, rx_byte_o}, 32'h22);
    spi_cs_ni = 1'b1;
    tick(2);

    // Abort after 5 bits, then a full byte 81
    tx_byte_i = 8'h81;
    tick(2);
    spi_cs_ni = 1'b0;
    tick(2);
    v0 = vcount;
    send_bits(8'hF0, 5, 1'b0, 1'b0, 8'h00, seen);
    spi_cs_ni = 1'b1;
    tick(3);
    check("abort_no_valid", vcount - v0, 32'd0);
    check("abort_rx_held", {24'd0, rx_byte_o}, 32'h22);
    check("abort_preload_msb", {31'd0, spi_tx_o}, 32'd1);
    spi_cs_ni = 1'b0;
    tick(2);
    v0 = vcount;
    send_bits(8'h81, 8, 1'b0, 1'b0, 8'h00, seen);
    check("after_abort_pin", {24'd0, seen}, 32'h81);
    check("after_abort_rx", {24'd0, rx_byte_o}, 32'h81);
    check("after_abort_valid", vcount - v0, 32'd1);
    spi_cs_ni = 1'b1;
    tick(2);

    // Reset in the middle of a byte (after bit 4)
    tx_byte_i = 8'hC6;
    tick(2);
    spi_cs_ni = 1'b0;
    tick(2);
    send_bits(8'hB4, 4, 1'b0, 1'b0, 8'h00, seen);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    tick(1);
    check("midreset_rx_byte", {24'd0, rx_byte_o}, 32'h00);
    check("midreset_tx_pin", {31'd0, spi_tx_o}, 32'd0);
    check("midreset_valid", {31'd0, valid_o}, 32'd0);
    tx_byte_i = 8'h3C;
    spi_cs_ni = 1'b1;
    tick(2);
    spi_cs_ni = 1'b0;
    tick(2);
    v0 = vcount;
    send_bits(8'h96, 8, 1'b0, 1'b0, 8'h00, seen);
    check("postreset_pin", {24'd0, seen}, 32'h3C);
    check("postreset_rx", {24'd0, rx_byte_o}, 32'h96);
    check("postreset_valid", vcount - v0, 32'd1);
    spi_cs_ni = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
